pack_recv: RTL

PACK_RECV -- requirements
Module: pack_recv

---
 rtl/pack_recv_pkg.sv | 25 ++
 rtl/pack_recv_syncdet.sv | 34 +++
 rtl/pack_recv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pack_recv_pkg.sv
// Shared constants and types for the sync-framed packet receiver.
// A frame is 16 bytes that pair into 8 little-endian words.
package pack_recv_pkg;

    localparam logic [31:0] SYNC_PATTERN    = 32'hFFFF_FF7F;
    localparam int          FRAME_BYTES     = 16;
    localparam int          WORDS_PER_FRAME = 8;
    localparam int          IDX_W           = $clog2(FRAME_BYTES);

    typedef logic [IDX_W-1:0] idx_t;

    // An aligned frame ends its sync pattern on this byte index
    localparam idx_t SYNC_IDX = idx_t'(3);
    localparam idx_t LAST_IDX = idx_t'(2 * WORDS_PER_FRAME - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } state_e;

    function automatic logic [15:0] make_word(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/pack_recv_syncdet.sv
// Sliding window over the last accepted bytes; match fires in the cycle
// the byte completing FF,FF,FF,7F is shifted in.
module pack_recv_syncdet
    import pack_recv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shift,
    input  logic [7:0] shift_byte,
    output logic       match
);

    // Three stored bytes plus the incoming one form the 4-byte window
    logic [23:0] win_q, win_d;
    logic [31:0] window;

    always_comb begin
        window = {win_q, shift_byte};
        win_d  = win_q;
        if (shift) begin
            win_d = window[23:0];
        end
        match = shift && (window == SYNC_PATTERN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

endmodule

// File: rtl/pack_recv.sv
// Packet receiver: hunts for the sync pattern, then reassembles each frame
// into words, reporting realignments, sync loss and strobe protocol errors.
module pack_recv
    import pack_recv_pkg::*;
#(
    parameter int SYNC_LOSS_LOG2 = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  DataVal,
    input  logic        DataReady,
    output logic [15:0] PacketWd,
    output logic        WdAvail,
    output logic        PacketReset,
    output logic        Sync,
    output logic        ResyncErr,
    output logic        ProtoErr
);

    localparam int                 TIMER_W    = SYNC_LOSS_LOG2 + 1;
    localparam logic [TIMER_W-1:0] LOSS_LIMIT = {1'b1, {SYNC_LOSS_LOG2{1'b0}}};

    state_e             state_q, state_d;
    idx_t               idx_q, idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
    logic [2:0][7:0]    held_q, held_d;
    logic               pend_q, pend_d;
    logic               part_q, part_d;
    logic               acc_prev_q, acc_prev_d;
    logic [15:0]        wd_q, wd_d;
    logic               wd_avail_q, wd_avail_d;
    logic               pkt_rst_q, pkt_rst_d;
    logic               resync_q, resync_d;
    logic               proto_q, proto_d;

    logic accept;
    logic drop;
    logic match;
    logic timeout;

    pack_recv_syncdet u_syncdet (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift      (accept),
        .shift_byte (DataVal),
        .match      (match)
    );

    // A strobe right after an accepted one is a protocol violation and is dropped
    always_comb begin
        accept    = DataReady && !acc_prev_q;
        drop      = DataReady && acc_prev_q;
        timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
        timeout   = (state_q == SYNCED) && (timer_inc == LOSS_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        held_d     = held_q;
        pend_d     = 1'b0;
        part_d     = part_q;
        acc_prev_d = accept;
        wd_d       = wd_q;
        wd_avail_d = 1'b0;
        pkt_rst_d  = 1'b0;
        resync_d   = 1'b0;
        proto_d    = drop;

        if (state_q == HUNT) begin
            timer_d = '0;
            if (match) begin
                state_d = SYNCED;
                idx_d   = '0;
                part_d  = 1'b0;
            end
        end else begin
            timer_d = timer_inc;
            if (match) begin
                timer_d = '0;
                idx_d   = '0;
                part_d  = 1'b0;
                if (idx_q != SYNC_IDX) begin
                    resync_d  = 1'b1;
                    pkt_rst_d = part_q;
                end
            end else if (timeout) begin
                // A pending second word is abandoned along with the frame
                state_d   = HUNT;
                timer_d   = '0;
                idx_d     = '0;
                pkt_rst_d = part_q;
                part_d    = 1'b0;
            end else begin
                if (pend_q) begin
                    wd_d       = make_word(held_q[0], held_q[1]);
                    wd_avail_d = 1'b1;
                end
                if (accept) begin
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + idx_t'(1);
                    case (idx_q)
                        idx_t'(0): held_d[0] = DataVal;
                        idx_t'(1): held_d[1] = DataVal;
                        idx_t'(2): held_d[2] = DataVal;
                        SYNC_IDX: begin
                            // Emit word 0 now and park word 1 in the held slots
                            wd_d       = make_word(held_q[0], held_q[1]);
                            wd_avail_d = 1'b1;
                            held_d[0]  = held_q[2];
                            held_d[1]  = DataVal;
                            pend_d     = 1'b1;
                            part_d     = 1'b1;
                        end
                        default: begin
                            if (idx_q[0]) begin
                                wd_d       = make_word(held_q[0], DataVal);
                                wd_avail_d = 1'b1;
                                if (idx_q == LAST_IDX) begin
                                    part_d = 1'b0;
                                end
                            end else begin
                                held_d[0] = DataVal;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            idx_q      <= '0;
            timer_q    <= '0;
            held_q     <= '0;
            pend_q     <= 1'b0;
            part_q     <= 1'b0;
            acc_prev_q <= 1'b0;
            wd_q       <= '0;
            wd_avail_q <= 1'b0;
            pkt_rst_q  <= 1'b0;
            resync_q   <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            held_q     <= held_d;
            pend_q     <= pend_d;
            part_q     <= part_d;
            acc_prev_q <= acc_prev_d;
            wd_q       <= wd_d;
            wd_avail_q <= wd_avail_d;
            pkt_rst_q  <= pkt_rst_d;
            resync_q   <= resync_d;
            proto_q    <= proto_d;
        end
    end

    assign PacketWd    = wd_q;
    assign WdAvail     = wd_avail_q;
    assign PacketReset = pkt_rst_q;
    assign Sync        = (state_q == SYNCED);
    assign ResyncErr   = resync_q;
    assign ProtoErr    = proto_q;

endmodule
